// File: rtl/maze_renderer.sv
// maze_renderer: walks the tile map in raster order, fetches one wall flag per
// tile from a synchronous map RAM and streams the 256 pixels of each tile to the
// frame-buffer writer over a valid/ready port. Screen coordinates are formed by
// concatenating tile and tile-local counters, so no adders are needed there.
module maze_renderer #(
    parameter int          TILES_X = 40,
    parameter int          TILES_Y = 30,
    parameter logic [23:0] BG_RGB  = 24'h000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [10:0] map_addr,
    input  logic        map_data,
    output logic [3:0]  rom_x,
    output logic [3:0]  rom_y,
    input  logic [7:0]  rom_r,
    input  logic [7:0]  rom_g,
    input  logic [7:0]  rom_b,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [9:0]  wr_x,
    output logic [8:0]  wr_y,
    output logic [7:0]  wr_r,
    output logic [7:0]  wr_g,
    output logic [7:0]  wr_b
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MAP_RD   = 3'd1,
        S_MAP_WAIT = 3'd2,
        S_PIX      = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam logic [5:0]  TX_LAST   = 6'(TILES_X - 1);
    localparam logic [4:0]  TY_LAST   = 5'(TILES_Y - 1);
    localparam logic [10:0] TX_STRIDE = 11'(TILES_X);

    state_t     state_r, state_s;
    logic [5:0] tx_r, tx_s;
    logic [4:0] ty_r, ty_s;
    logic [3:0] px_r, px_s;
    logic [3:0] py_r, py_s;
    logic       wall_r, wall_s;
    logic       busy_r, done_r, wr_valid_r;
    logic       tile_end_s, last_tile_s;

    // Next-state, counter and wall-flag logic for the tile/pixel walk.
    always_comb begin
        state_s     = state_r;
        tx_s        = tx_r;
        ty_s        = ty_r;
        px_s        = px_r;
        py_s        = py_r;
        wall_s      = wall_r;
        tile_end_s  = (px_r == 4'd15) && (py_r == 4'd15);
        last_tile_s = (tx_r == TX_LAST) && (ty_r == TY_LAST);
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_MAP_RD;
                    tx_s    = 6'd0;
                    ty_s    = 5'd0;
                    px_s    = 4'd0;
                    py_s    = 4'd0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_MAP_RD: begin
                state_s = S_MAP_WAIT;
            end
            S_MAP_WAIT: begin
                wall_s  = map_data;
                state_s = S_PIX;
            end
            S_PIX: begin
                if (wr_valid_r && wr_ready) begin
                    px_s = px_r + 4'd1;
                    if (px_r == 4'd15) begin
                        py_s = py_r + 4'd1;
                    end else begin
                        py_s = py_r;
                    end
                    if (tile_end_s) begin
                        if (last_tile_s) begin
                            // Leave counters at zero so an idle engine addresses tile 0.
                            state_s = S_DONE;
                            tx_s    = 6'd0;
                            ty_s    = 5'd0;
                        end else begin
                            state_s = S_MAP_RD;
                            if (tx_r == TX_LAST) begin
                                tx_s = 6'd0;
                                ty_s = ty_r + 5'd1;
                            end else begin
                                tx_s = tx_r + 6'd1;
                                ty_s = ty_r;
                            end
                        end
                    end else begin
                        state_s = S_PIX;
                    end
                end else begin
                    state_s = S_PIX;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State, counters and registered status flags; reset abandons any frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= S_IDLE;
            tx_r       <= 6'd0;
            ty_r       <= 5'd0;
            px_r       <= 4'd0;
            py_r       <= 4'd0;
            wall_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            wr_valid_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            tx_r       <= tx_s;
            ty_r       <= ty_s;
            px_r       <= px_s;
            py_r       <= py_s;
            wall_r     <= wall_s;
            busy_r     <= (state_s != S_IDLE);
            done_r     <= (state_s == S_DONE);
            wr_valid_r <= (state_s == S_PIX);
        end
    end

    // Tile index: multiply by a constant stride, folds into shifts and adds.
    assign map_addr = ({6'd0, ty_r} * TX_STRIDE) + {5'd0, tx_r};

    assign busy     = busy_r;
    assign done     = done_r;
    assign wr_valid = wr_valid_r;
    assign rom_x    = px_r;
    assign rom_y    = py_r;
    assign wr_x     = {tx_r, px_r};
    assign wr_y     = {ty_r, py_r};
    assign wr_r     = wall_r ? rom_r : BG_RGB[23:16];
    assign wr_g     = wall_r ? rom_g : BG_RGB[15:8];
    assign wr_b     = wall_r ? rom_b : BG_RGB[7:0];

endmodule
